result_display: RTL and testbench
=================================

RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles each digit stays active; legal range 2 to 2^24-1.
REQ-002 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port processor_result  input  32  result word from the processor core.
REQ-005 Port update_display_en  input  1  high in a cycle where processor_result is valid to show.
REQ-006 Port page_sel  input  1  asynchronous switch: 0 = show bits [15:0], 1 = show bits [31:16].
REQ-007 Port seg  output  7  active-low segments {g,f,e,d,c,b,a} of the active digit.
REQ-008 Port an  output  4  active-low digit enables; an[0] = rightmost digit.
REQ-009 Port dp  output  1  active-low decimal point.
REQ-010 Port led  output  16  count of accepted updates, saturating.

Function
REQ-011 Any cycle with update_display_en=1 loads processor_result into a 32-bit hold register at the next edge; the held value is otherwise unchanged.
REQ-012 Hold register feeds the digit mux with one cycle of latency: a new value appears on seg in the cycle after capture, while its digit is active.
REQ-013 page_sel passes through a 2-flop synchroniser; the synchronised page applies from the third edge after the input changes.
REQ-014 Shown half-word: hold[15:0] when the synchronised page is 0, hold[31:16] when it is 1; digit k shows nibble k of that half.
REQ-015 Refresh counter counts 0..REFRESH_DIV-1 and wraps to 0; the scan index (2 bits) advances 0→1→2→3→0 only on the wrap cycle.
REQ-016 an has exactly one bit low at all times outside reset: an[k]=0 when the scan index is k.
REQ-017 seg is the hex-to-seven-segment code of the selected nibble (0..F). Examples: 0→7'b1000000, 8→7'b0000000, A→7'b0001000, F→7'b0001110.
REQ-018 dp=0 only when scan index=3 and the synchronised page=1; otherwise dp=1.
REQ-019 led increments by 1 for each cycle with update_display_en=1, saturating at 16'hFFFF (it does not wrap).
REQ-020 seg, an and dp are registered: they change together on one edge, so no glitch between digit switch and segment data.
REQ-021 A page change mid-scan does not reset the scan index or the refresh counter.

Reset
REQ-022 While rst=0, these values are held regardless of clk:
- hold = 0
- led = 0
- refresh counter = 0
- scan index = 0
- synchroniser flops = 0
- an = 4'b1110
- seg = 7'b1000000
- dp = 1
REQ-023 Capture is blocked during reset: update_display_en asserted while rst=0 has no effect.
REQ-024 On release, refresh counting starts at the first rising edge after rst goes high; a reset applied mid-scan returns immediately to the REQ-022 values.

Structure
REQ-025 A shared package holds:
- the 16-entry hex-to-segment constant table;
- the width constants DIGITS=4 and SEG_W=7;
- the default REFRESH_DIV.
REQ-026 The nibble decode is one combinational sub-module named hex_to_7seg, instantiated once after the digit mux.
REQ-027 Refresh counter width is derived from REFRESH_DIV; there are no hard-coded clock-frequency constants.

Verification (bench uses REFRESH_DIV=4)
REQ-028 Reset: hold rst=0 for 3 cycles with update_display_en=1 and processor_result=32'hDEADBEEF -> an=1110, seg=1000000, dp=1 and led=0 throughout; after release, hold still reads 0.
REQ-029 Capture/scan: after release, pulse update_display_en=1 for 1 cycle with 32'h1234ABCD, page_sel=0 -> digits 0..3 show D,C,B,A and each is active for exactly 4 cycles; led=1.
REQ-030 Page: set page_sel=1 -> within 3 cycles the digits show 4,3,2,1, and dp=0 only while an=0111.
REQ-031 Back-to-back: update_display_en held high for 3 cycles with 32'h00000001, 32'h00000002, 32'h00000003 -> hold=32'h00000003 and led=3.
REQ-032 Saturation: preload led to 16'hFFFE (force), then 3 update cycles -> led=16'hFFFF and stays there.
REQ-033 Mid-scan reset: assert rst=0 while an=1011 -> outputs go to REQ-022 values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/result_display_pkg.sv
// Shared constants for the result display block.
//   DIGITS / SEG_W       : digit count and segment bus width
//   REFRESH_DIV_DEFAULT  : default clock cycles each digit stays lit
//   SEG_TABLE            : active-low {g,f,e,d,c,b,a} codes for hex 0..F
//   page_e               : which half of the held word is shown
package result_display_pkg;

  localparam int unsigned DIGITS              = 4;
  localparam int unsigned SEG_W               = 7;
  localparam int unsigned NIB_W               = 4;
  localparam int unsigned REFRESH_DIV_DEFAULT = 100000;

  typedef logic [SEG_W-1:0] seg_t;

  typedef enum logic {
    PAGE_LOW  = 1'b0,
    PAGE_HIGH = 1'b1
  } page_e;

  localparam seg_t SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Nibble idx of a 16-bit half-word.
  function automatic logic [NIB_W-1:0] select_nibble(input logic [15:0] half,
                                                     input logic [1:0]  idx);
    return half[{idx, 2'b00} +: NIB_W];
  endfunction

endpackage

// File: rtl/result_display_hex_to_7seg.sv
// Combinational hex digit to seven-segment decoder.
//   hex : 4-bit value 0..F
//   seg : active-low segments {g,f,e,d,c,b,a}
module hex_to_7seg
  import result_display_pkg::*;
(
  input  logic [NIB_W-1:0] hex,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_TABLE[hex];
  end

endmodule

// File: rtl/result_display.sv
// Four-digit multiplexed seven-segment display of a processor result.
//   clk               : system clock, rising edge
//   rst               : asynchronous active-low reset
//   processor_result  : 32-bit word captured when update_display_en is high
//   update_display_en : capture strobe
//   page_sel          : asynchronous page switch (0 = [15:0], 1 = [31:16])
//   seg               : active-low segments of the active digit
//   an                : active-low digit enables, an[0] is the rightmost digit
//   dp                : active-low decimal point, lit on digit 3 of the high page
//   led               : saturating count of accepted updates
module result_display
  import result_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       processor_result,
  input  logic              update_display_en,
  input  logic              page_sel,
  output logic [SEG_W-1:0]  seg,
  output logic [DIGITS-1:0] an,
  output logic              dp,
  output logic [15:0]       led
);

  localparam int unsigned     CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [31:0]       hold_q,  hold_d;
  logic [15:0]       led_q,   led_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [1:0]        scan_q,  scan_d;
  logic              sync1_q, sync1_d;
  page_e             sync2_q, sync2_d;
  logic [SEG_W-1:0]  seg_q,   seg_d;
  logic [DIGITS-1:0] an_q,    an_d;
  logic              dp_q,    dp_d;

  logic [15:0]       shown_half;
  logic [NIB_W-1:0]  nibble;
  logic [SEG_W-1:0]  seg_dec;

  // Digit mux works from the registered hold value, so a fresh capture
  // reaches seg one edge later.
  always_comb begin
    shown_half = (sync2_q == PAGE_HIGH) ? hold_q[31:16] : hold_q[15:0];
    nibble     = select_nibble(shown_half, scan_q);
  end

  hex_to_7seg u_hex_to_7seg (
    .hex (nibble),
    .seg (seg_dec)
  );

  always_comb begin
    hold_d  = hold_q;
    led_d   = led_q;
    cnt_d   = cnt_q + CNT_W'(1);
    scan_d  = scan_q;
    sync1_d = page_sel;
    sync2_d = page_e'(sync1_q);

    if (update_display_en) begin
      hold_d = processor_result;
      if (led_q != '1) begin
        led_d = led_q + 16'd1;
      end
    end

    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      scan_d = scan_q + 2'd1;
    end

    // Segment data, enable and dp all derive from the same scan index and
    // are registered together so the digit switch never shows stale data.
    seg_d = seg_dec;
    an_d  = ~(DIGITS'(1) << scan_q);
    dp_d  = !((scan_q == 2'd3) && (sync2_q == PAGE_HIGH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q  <= '0;
      led_q   <= '0;
      cnt_q   <= '0;
      scan_q  <= '0;
      sync1_q <= 1'b0;
      sync2_q <= PAGE_LOW;
      seg_q   <= SEG_TABLE[0];
      an_q    <= 4'b1110;
      dp_q    <= 1'b1;
    end else begin
      hold_q  <= hold_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      scan_q  <= scan_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;
  assign led = led_q;

endmodule

// File: tb/tb_result_display.sv
module tb_result_display;

  localparam int unsigned DIV = 4;

  localparam logic [6:0] TB_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] processor_result;
  logic        update_display_en;
  logic        page_sel;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [15:0] led;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int unsigned m_cnt = 0;
  int unsigned m_upd = 0;
  int          led_base = 0;
  logic [31:0] m_hold = '0;
  bit          m_pq[$];
  logic [6:0]  e_seg = 7'h40;
  logic [3:0]  e_an  = 4'b1110;
  logic        e_dp  = 1'b1;

  result_display #(.REFRESH_DIV(DIV)) dut (
    .clk               (clk),
    .rst               (rst),
    .processor_result  (processor_result),
    .update_display_en (update_display_en),
    .page_sel          (page_sel),
    .seg               (seg),
    .an                (an),
    .dp                (dp),
    .led               (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: outputs after edge n come from the scan position n-1 edges into
  // the run, the hold value before the edge and page_sel sampled two edges back.
  initial begin
    int unsigned digit;
    bit          pg;
    logic [15:0] half;
    logic [3:0]  nib;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_cnt  = 0;
        m_upd  = 0;
        m_hold = '0;
        m_pq.delete();
        e_seg  = 7'h40;
        e_an   = 4'b1110;
        e_dp   = 1'b1;
      end else begin
        pg    = (m_pq.size() >= 2) ? m_pq[m_pq.size()-2] : 1'b0;
        digit = (m_cnt / DIV) % 4;
        half  = pg ? m_hold[31:16] : m_hold[15:0];
        nib   = 4'((half >> (4 * digit)) & 16'hF);
        e_seg = TB_SEG[nib];
        e_an  = 4'(~(32'h1 << digit));
        e_dp  = !(digit == 3 && pg);
        if (update_display_en) begin
          m_hold = processor_result;
          m_upd++;
        end
        m_pq.push_back(page_sel);
        if (m_pq.size() > 2) void'(m_pq.pop_front());
        m_cnt++;
      end
    end
  end

  // Per-cycle compare on the falling edge.
  initial begin
    int exp_led;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rst_an",   32'(an),  32'(4'b1110));
        check("rst_seg",  32'(seg), 32'(7'b1000000));
        check("rst_dp",   32'(dp),  32'(1'b1));
        check("rst_led",  32'(led), 32'h0);
        check("rst_hold", dut.hold_q, 32'h0);
      end else begin
        exp_led = led_base + int'(m_upd);
        if (exp_led > 65535) exp_led = 65535;
        check("an",   32'(an),  32'(e_an));
        check("seg",  32'(seg), 32'(e_seg));
        check("dp",   32'(dp),  32'(e_dp));
        check("led",  32'(led), 32'(exp_led));
        check("hold", dut.hold_q, m_hold);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_an(input logic [3:0] target);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an == target) found = 1;
    end
    check("wait_an", 32'(found), 32'h1);
  endtask

  initial begin
    int run;
    rst               = 1'b0;
    update_display_en = 1'b1;
    processor_result  = 32'hDEADBEEF;
    page_sel          = 1'b0;

    // Reset held with capture strobe active
    repeat (3) @(negedge clk);
    check("lit_rst_seg", 32'(seg), 32'(7'b1000000));
    #1;
    update_display_en = 1'b0;
    rst               = 1'b1;
    @(negedge clk);
    check("lit_hold_after_rst", dut.hold_q, 32'h0);

    // Single capture, low page
    #1;
    processor_result  = 32'h1234ABCD;
    update_display_en = 1'b1;
    step();
    update_display_en = 1'b0;
    @(negedge clk);
    check("lit_led_1", 32'(led), 32'd1);
    @(negedge clk);
    wait_an(4'b1101); check("lit_dig1_C", 32'(seg), 32'(7'b1000110));
    wait_an(4'b1011); check("lit_dig2_B", 32'(seg), 32'(7'b0000011));
    wait_an(4'b0111); check("lit_dig3_A", 32'(seg), 32'(7'b0001000));
    check("lit_dp_low_page", 32'(dp), 32'h1);
    wait_an(4'b1110); check("lit_dig0_D", 32'(seg), 32'(7'b0100001));
    wait_an(4'b1101);
    run = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an != 4'b1101) break;
      run++;
    end
    check("lit_digit_dwell", 32'(run), 32'd4);

    // High page
    #1;
    page_sel = 1'b1;
    repeat (3) @(negedge clk);
    wait_an(4'b1110); check("lit_hi_dig0_4", 32'(seg), 32'(7'b0011001));
    check("lit_hi_dp0", 32'(dp), 32'h1);
    wait_an(4'b1101); check("lit_hi_dig1_3", 32'(seg), 32'(7'b0110000));
    wait_an(4'b1011); check("lit_hi_dig2_2", 32'(seg), 32'(7'b0100100));
    wait_an(4'b0111); check("lit_hi_dig3_1", 32'(seg), 32'(7'b1111001));
    check("lit_hi_dp3", 32'(dp), 32'h0);

    // Asynchronous reset mid-scan
    wait_an(4'b1011);
    #1;
    rst      = 1'b0;
    led_base = 0;
    #1;
    check("lit_async_an",  32'(an),  32'(4'b1110));
    check("lit_async_seg", 32'(seg), 32'(7'b1000000));
    check("lit_async_dp",  32'(dp),  32'h1);
    check("lit_async_led", 32'(led), 32'h0);
    step();
    rst      = 1'b1;
    page_sel = 1'b0;
    step();

    // Back-to-back captures
    update_display_en = 1'b1;
    processor_result  = 32'h00000001;
    step();
    processor_result  = 32'h00000002;
    step();
    processor_result  = 32'h00000003;
    step();
    update_display_en = 1'b0;
    @(negedge clk);
    check("lit_b2b_hold", dut.hold_q, 32'h00000003);
    check("lit_b2b_led",  32'(led), 32'd3);

    // Saturation
    #1;
    led_base = 65534 - int'(m_upd);
    force dut.led_q = 16'hFFFE;
    #1;
    release dut.led_q;
    step();
    update_display_en = 1'b1;
    repeat (3) step();
    update_display_en = 1'b0;
    @(negedge clk);
    check("lit_sat_led", 32'(led), 32'h0000FFFF);
    #1;
    update_display_en = 1'b1;
    repeat (2) step();
    update_display_en = 1'b0;
    repeat (2) @(negedge clk);
    check("lit_sat_hold", 32'(led), 32'h0000FFFF);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
